// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches from imem over ready/valid,
// and presents the instruction until the control path retires it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] SignImm,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] instr_count,
    output logic        imem_timeout
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] W_MAX   = CW'(TIMEOUT);
    localparam logic [0:0]    S_FETCH = 1'b0;
    localparam logic [0:0]    S_EXEC  = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_req;
    logic [31:0]   r_count;
    logic          r_timeout;
    logic [CW-1:0] r_wait;

    logic [31:0]   w_pc4;
    logic [31:0]   w_br;
    logic [31:0]   w_jmp;
    logic [31:0]   w_npc;
    logic          w_accept;
    logic          w_retire;
    logic          w_stall;
    logic [CW-1:0] w_wait_nxt;

    assign w_pc4    = r_pc + 32'd4;
    assign w_br     = w_pc4 + {SignImm[29:0], 2'b00};
    assign w_jmp    = {w_pc4[31:28], r_instr[25:0], 2'b00};
    // r_req is only ever set while in FETCH, so it qualifies the handshake
    assign w_accept = r_req && imem_ready;
    assign w_retire = (r_state == S_EXEC) && advance;
    assign w_stall  = r_req && !imem_ready;
    assign w_wait_nxt = (r_wait == W_MAX) ? r_wait : r_wait + 1'b1;

    // Next-PC select: jump beats branch beats sequential
    always_comb begin
        w_npc = w_pc4;
        if (Jump)
            w_npc = w_jmp;
        else if (PCSrc)
            w_npc = w_br;
    end

    // Fetch/execute sequencing, PC update and retirement counting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else if (r_state == S_FETCH) begin
            if (w_accept) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
                r_state <= S_EXEC;
            end
        end else if (w_retire) begin
            r_pc    <= w_npc;
            r_count <= r_count + 32'd1;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
        end
    end

    // Registered request: low right after reset, high whenever next state is FETCH
    always_ff @(posedge clk) begin
        if (reset)
            r_req <= 1'b0;
        else
            r_req <= ((r_state == S_FETCH) && !w_accept) || w_retire;
    end

    // Wait counter (saturating) and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_wait <= '0;
        end else if (w_stall) begin
            r_wait <= w_wait_nxt;
            if (w_wait_nxt == W_MAX)
                r_timeout <= 1'b1;
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign Instr        = r_instr;
    assign Opcode       = r_instr[31:26];
    assign Funct        = r_instr[5:0];
    assign instr_valid  = r_valid;
    assign PC           = r_pc;
    assign PCPlus4      = w_pc4;
    assign instr_count  = r_count;
    assign imem_timeout = r_timeout;

endmodule
